avalon_st_pkt_stats: RTL and testbench
======================================

Name: avalon_st_pkt_stats

Overview:
- Parametrised Avalon-ST packet statistics tap; successor to the single-counter word counter.
- Inserted on any avalon_st_if link in the onboard-debug path, either as a transparent pass-through or as a terminating always-ready sink.
- Tracks the word count of the in-flight packet, latches the length of the last completed packet, and counts completed packets and framing errors.
- Counters saturate or wrap, selected by parameter.

Parameters:
- LEN_W, 16: width of cur_len and last_len.
- CNT_W, 32: width of pkt_cnt and err_cnt.
- SATURATE, 1: 1 = all counters hold at all-ones; 0 = counters wrap modulo 2^width.
- PASS_THROUGH, 1: 1 = forward msg_in to msg_out; 0 = terminating sink.

Ports:
- clk  in  1  single clock; all state changes on posedge clk.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- msg_in  avalon_st_if.slave  iface  monitored stream.
- msg_out  avalon_st_if.master  iface  forwarded stream; used only when PASS_THROUGH=1.
- clear  in  1  synchronous clear of statistics.
- in_pkt  out  1  1 while state is IN_PKT.
- cur_len  out  LEN_W  words accepted so far in the current packet.
- last_len  out  LEN_W  length of the last completed packet.
- last_len_vld  out  1  one-cycle pulse when last_len updates.
- len_ovf  out  1  sticky; the last completed packet saturated or wrapped cur_len.
- pkt_cnt  out  CNT_W  completed packets.
- err_cnt  out  CNT_W  framing errors.
- err_orphan  out  1  pulse: beat with sop=0 received in IDLE.
- err_restart  out  1  pulse: beat with sop=1 received in IN_PKT.

Behaviour:
- Data path, PASS_THROUGH=1:
  - msg_out valid, sop, eop and data are driven combinationally from msg_in.
  - msg_in.ready is driven combinationally from msg_out.ready; zero added latency.
- Data path, PASS_THROUGH=0:
  - msg_in.ready is tied to 1.
  - msg_out.valid is tied to 0.
- Beat definition: beat = msg_in.valid & msg_in.ready. Only beats are counted; valid without ready counts nothing.
- Output timing: all outputs except the data path are registered and reflect a beat on the following cycle.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All counters, last_len, len_ovf and pulses go to 0.
  - Reset mid-packet discards the packet silently; no error is counted.
- State IDLE:
  - beat, sop=1, eop=1: last_len=1, last_len_vld=1, pkt_cnt+1, len_ovf=0, cur_len=1; stay in IDLE.
  - beat, sop=1, eop=0: cur_len=1; go to IN_PKT.
  - beat, sop=0: err_orphan=1, err_cnt+1, cur_len unchanged; stay in IDLE. The orphan beat is still forwarded.
- State IN_PKT:
  - beat, sop=0, eop=0: cur_len+1.
  - beat, sop=0, eop=1: last_len=cur_len+1, last_len_vld=1, pkt_cnt+1, len_ovf=the overflow state of this packet; go to IDLE.
  - beat, sop=1: err_restart=1, err_cnt+1, the old packet is abandoned without updating pkt_cnt, cur_len=1.
    - If eop=0: stay in IN_PKT.
    - If eop=1: complete a 1-word packet as in IDLE and go to IDLE.
- Overflow, SATURATE=1: cur_len, pkt_cnt and err_cnt hold at all-ones.
- Overflow, SATURATE=0: counters wrap.
- Either mode: any cur_len overflow within a packet sets an internal flag. The flag is copied to len_ovf at eop and cleared at sop.
- clear:
  - Zeroes pkt_cnt, err_cnt, last_len and len_ovf.
  - Does not touch state or cur_len.
  - Clear together with an increment in the same cycle: the result is the increment applied to 0, so no event is lost.
- Pulses (last_len_vld, err_orphan, err_restart) last exactly one cycle per triggering beat. They may be back-to-back on consecutive beats.

Decomposition:
- Package (aes_top_pack or a debug package):
  - pkt_stats_state_e enum {IDLE, IN_PKT}.
  - Default widths PKT_LEN_W and PKT_CNT_W.
- Sub-module sat_counter:
  - Parameters WIDTH and SATURATE; inputs inc and clr.
  - Outputs value and ovf (overflow event).
  - Instantiated three times: cur_len, pkt_cnt, err_cnt.

Test Plan:
- Reset then 3 packets of lengths 1, 4, 7 with no gaps -> last_len sequence 1, 4, 7; three last_len_vld pulses; pkt_cnt=3; err_cnt=0.
- 5-word packet with msg_out.ready deasserted on words 2-3 (PASS_THROUGH=1) -> last_len=5, not 7; msg_in.ready follows msg_out.ready in the same cycle.
- Beat with sop=0 in IDLE, then sop at word 3 of a packet, then 2 more words ending with eop -> err_orphan pulse, err_restart pulse, err_cnt=2, last_len=3, pkt_cnt=1.
- LEN_W=3, SATURATE=1, 10-word packet -> cur_len sticks at 7, last_len=7, len_ovf=1. Repeat with SATURATE=0 -> last_len=2, len_ovf=1.
- clear asserted in the same cycle as an eop beat with pkt_cnt=5 -> pkt_cnt=1 next cycle, last_len=packet length; cur_len behaviour unaffected.
- rst_n low for one cycle at word 2 of a packet, then a 2-word packet -> all outputs 0 after reset; then last_len=2, pkt_cnt=1, err_cnt=0.

Source files
------------

// File: rtl/avalon_st_pkt_stats_pkg.sv
// Shared types and default widths for the Avalon-ST packet statistics tap.
package avalon_st_pkt_stats_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pkt_stats_state_e;

   localparam int PKT_LEN_W = 16;
   localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/avalon_st_if.sv
// Minimal Avalon-ST link: valid/ready handshake with packet framing.
interface avalon_st_if #(
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic              sop;
   logic              eop;
   logic [DATA_W-1:0] data;

   modport master (output valid, output sop, output eop, output data, input ready);
   modport slave  (input valid, input sop, input eop, input data, output ready);
endinterface

// File: rtl/avalon_st_pkt_stats_sat_counter.sv
// Counter with synchronous clear and increment; saturates or wraps.
// Clear and increment together yield 1, so no event is lost on a clear.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             ovf
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] base;

   // Next value: start from 0 on clear, flag overflow when incrementing all-ones.
   always_comb begin
      base    = clr ? '0 : value_q;
      ovf     = inc && (base == {WIDTH{1'b1}});
      value_d = base;
      if (inc && !(ovf && SATURATE)) begin
         value_d = base + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/avalon_st_pkt_stats.sv
// Avalon-ST packet statistics tap: pass-through or always-ready sink that
// tracks packet length, completed packets and framing errors.
module avalon_st_pkt_stats
   import avalon_st_pkt_stats_pkg::*;
#(
   parameter int LEN_W        = PKT_LEN_W,
   parameter int CNT_W        = PKT_CNT_W,
   parameter bit SATURATE     = 1'b1,
   parameter bit PASS_THROUGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   avalon_st_if.slave       msg_in,
   avalon_st_if.master      msg_out,
   input  logic             clear,
   output logic             in_pkt,
   output logic [LEN_W-1:0] cur_len,
   output logic [LEN_W-1:0] last_len,
   output logic             last_len_vld,
   output logic             len_ovf,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_orphan,
   output logic             err_restart
);

   pkt_stats_state_e state_q, state_d;
   logic [LEN_W-1:0] last_len_q, last_len_d;
   logic             last_len_vld_q, last_len_vld_d;
   logic             len_ovf_q, len_ovf_d;
   logic             ovf_flag_q, ovf_flag_d;
   logic             err_orphan_q, err_orphan_d;
   logic             err_restart_q, err_restart_d;

   logic             beat;
   logic             is_idle;
   logic             orphan;
   logic             restart;
   logic             complete;
   logic             cur_inc;
   logic             cur_clr;
   logic             cur_ovf;
   logic             pkt_ovf;
   logic             err_ovf;

   // Data path: zero-latency forwarding, or a terminating always-ready sink.
   if (PASS_THROUGH) begin : g_pass
      assign msg_out.valid = msg_in.valid;
      assign msg_out.sop   = msg_in.sop;
      assign msg_out.eop   = msg_in.eop;
      assign msg_out.data  = msg_in.data;
      assign msg_in.ready  = msg_out.ready;
   end else begin : g_sink
      assign msg_out.valid = 1'b0;
      assign msg_out.sop   = 1'b0;
      assign msg_out.eop   = 1'b0;
      assign msg_out.data  = '0;
      assign msg_in.ready  = 1'b1;
   end

   // Beat classification and next-state/statistics logic.
   always_comb begin
      beat     = msg_in.valid & msg_in.ready;
      is_idle  = (state_q == IDLE);
      orphan   = beat & ~msg_in.sop & is_idle;
      restart  = beat & msg_in.sop & ~is_idle;
      complete = beat & msg_in.eop & (msg_in.sop | ~is_idle);
      cur_inc  = beat & (msg_in.sop | ~is_idle);
      cur_clr  = beat & msg_in.sop;

      state_d = state_q;
      if (beat) begin
         if (msg_in.sop) begin
            state_d = msg_in.eop ? IDLE : IN_PKT;
         end else if (!is_idle && msg_in.eop) begin
            state_d = IDLE;
         end
      end

      ovf_flag_d = (cur_clr ? 1'b0 : ovf_flag_q) | cur_ovf;

      last_len_d = last_len_q;
      len_ovf_d  = len_ovf_q;
      if (complete) begin
         if (msg_in.sop) begin
            last_len_d = LEN_W'(1);
         end else if (cur_ovf) begin
            last_len_d = SATURATE ? cur_len : '0;
         end else begin
            last_len_d = cur_len + LEN_W'(1);
         end
         len_ovf_d = ovf_flag_d;
      end else if (clear) begin
         last_len_d = '0;
         len_ovf_d  = 1'b0;
      end

      last_len_vld_d = complete;
      err_orphan_d   = orphan;
      err_restart_d  = restart;
   end

   // State, latched length and pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         last_len_q     <= '0;
         last_len_vld_q <= 1'b0;
         len_ovf_q      <= 1'b0;
         ovf_flag_q     <= 1'b0;
         err_orphan_q   <= 1'b0;
         err_restart_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_len_q     <= last_len_d;
         last_len_vld_q <= last_len_vld_d;
         len_ovf_q      <= len_ovf_d;
         ovf_flag_q     <= ovf_flag_d;
         err_orphan_q   <= err_orphan_d;
         err_restart_q  <= err_restart_d;
      end
   end

   sat_counter #(.WIDTH(LEN_W), .SATURATE(SATURATE)) u_cur_len (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cur_inc),
      .clr   (cur_clr),
      .value (cur_len),
      .ovf   (cur_ovf)
   );

   sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_pkt_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (complete),
      .clr   (clear),
      .value (pkt_cnt),
      .ovf   (pkt_ovf)
   );

   sat_counter #(.WIDTH(CNT_W), .SATURATE(SATURATE)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (orphan | restart),
      .clr   (clear),
      .value (err_cnt),
      .ovf   (err_ovf)
   );

   assign in_pkt       = (state_q == IN_PKT);
   assign last_len     = last_len_q;
   assign last_len_vld = last_len_vld_q;
   assign len_ovf      = len_ovf_q;
   assign err_orphan   = err_orphan_q;
   assign err_restart  = err_restart_q;

endmodule

// File: tb/tb_avalon_st_pkt_stats.sv
// Bench for avalon_st_pkt_stats: a pass-through instance checked through a
// pulse scoreboard, plus two small sink instances for saturate/wrap overflow.
module tb_avalon_st_pkt_stats;

   typedef struct {
      int last_len;
      int pkt_cnt;
      int err_cnt;
      bit len_ovf;
   } pkt_exp_t;

   typedef struct {
      bit restart;
      int err_cnt;
   } err_exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_sop = 1'b0;
   logic       in_eop = 1'b0;
   logic [7:0] in_data = '0;
   logic       ds_ready = 1'b1;
   logic       clear = 1'b0;
   logic       small_en = 1'b0;

   int checks = 0;
   int errors = 0;

   pkt_exp_t pkt_q[$];
   err_exp_t err_q[$];
   pkt_exp_t pkt_e;
   err_exp_t err_e;

   always #5 clk = ~clk;

   avalon_st_if #(.DATA_W(8)) main_in ();
   avalon_st_if #(.DATA_W(8)) main_out ();
   avalon_st_if #(.DATA_W(8)) sat_in ();
   avalon_st_if #(.DATA_W(8)) sat_out ();
   avalon_st_if #(.DATA_W(8)) wrap_in ();
   avalon_st_if #(.DATA_W(8)) wrap_out ();

   assign main_in.valid  = in_valid & ~small_en;
   assign main_in.sop    = in_sop;
   assign main_in.eop    = in_eop;
   assign main_in.data   = in_data;
   assign main_out.ready = ds_ready;

   assign sat_in.valid   = in_valid & small_en;
   assign sat_in.sop     = in_sop;
   assign sat_in.eop     = in_eop;
   assign sat_in.data    = in_data;
   assign sat_out.ready  = 1'b1;

   assign wrap_in.valid  = in_valid & small_en;
   assign wrap_in.sop    = in_sop;
   assign wrap_in.eop    = in_eop;
   assign wrap_in.data   = in_data;
   assign wrap_out.ready = 1'b1;

   logic        m_in_pkt, m_vld, m_ovf, m_orphan, m_restart;
   logic [15:0] m_cur, m_last;
   logic [31:0] m_pkt, m_err;

   logic        s_in_pkt, s_vld, s_ovf, s_orphan, s_restart;
   logic [2:0]  s_cur, s_last;
   logic [7:0]  s_pkt, s_err;

   logic        w_in_pkt, w_vld, w_ovf, w_orphan, w_restart;
   logic [2:0]  w_cur, w_last;
   logic [7:0]  w_pkt, w_err;

   avalon_st_pkt_stats #(.LEN_W(16), .CNT_W(32), .SATURATE(1'b1), .PASS_THROUGH(1'b1)) dut (
      .clk (clk), .rst_n (rst_n), .msg_in (main_in), .msg_out (main_out), .clear (clear),
      .in_pkt (m_in_pkt), .cur_len (m_cur), .last_len (m_last), .last_len_vld (m_vld),
      .len_ovf (m_ovf), .pkt_cnt (m_pkt), .err_cnt (m_err),
      .err_orphan (m_orphan), .err_restart (m_restart)
   );

   avalon_st_pkt_stats #(.LEN_W(3), .CNT_W(8), .SATURATE(1'b1), .PASS_THROUGH(1'b0)) dut_sat (
      .clk (clk), .rst_n (rst_n), .msg_in (sat_in), .msg_out (sat_out), .clear (clear),
      .in_pkt (s_in_pkt), .cur_len (s_cur), .last_len (s_last), .last_len_vld (s_vld),
      .len_ovf (s_ovf), .pkt_cnt (s_pkt), .err_cnt (s_err),
      .err_orphan (s_orphan), .err_restart (s_restart)
   );

   avalon_st_pkt_stats #(.LEN_W(3), .CNT_W(8), .SATURATE(1'b0), .PASS_THROUGH(1'b0)) dut_wrap (
      .clk (clk), .rst_n (rst_n), .msg_in (wrap_in), .msg_out (wrap_out), .clear (clear),
      .in_pkt (w_in_pkt), .cur_len (w_cur), .last_len (w_last), .last_len_vld (w_vld),
      .len_ovf (w_ovf), .pkt_cnt (w_pkt), .err_cnt (w_err),
      .err_orphan (w_orphan), .err_restart (w_restart)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of input, verify the combinational pass-through, then clock it in.
   task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [7:0] d,
                                input bit rdy, input bit clr);
      in_valid = v;
      in_sop   = s;
      in_eop   = e;
      in_data  = d;
      ds_ready = rdy;
      clear    = clr;
      #1;
      if (!small_en) begin
         checkOutput("in_ready_follows_out_ready", main_in.ready, rdy);
         checkOutput("out_valid_follows_in_valid", main_out.valid, v);
         if (v) checkOutput("out_data_forwarded", main_out.data, d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic drivePacket(input int len, input int base);
      for (int i = 0; i < len; i++) begin
         applyStimulus(1'b1, i == 0, i == len - 1, 8'(base + i), 1'b1, 1'b0);
      end
   endtask

   task automatic expectPkt(input int ll, input int pc, input int ec, input bit ov);
      pkt_exp_t p;
      p.last_len = ll;
      p.pkt_cnt  = pc;
      p.err_cnt  = ec;
      p.len_ovf  = ov;
      pkt_q.push_back(p);
   endtask

   task automatic expectErr(input bit rs, input int ec);
      err_exp_t x;
      x.restart = rs;
      x.err_cnt = ec;
      err_q.push_back(x);
   endtask

   // Monitor: whenever the main DUT pulses, pop the expected event and compare.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_vld) begin
            if (pkt_q.size() == 0) begin
               checkOutput("unexpected_last_len_vld", 1, 0);
            end else begin
               pkt_e = pkt_q.pop_front();
               checkOutput("sb_last_len", m_last, pkt_e.last_len);
               checkOutput("sb_pkt_cnt", m_pkt, pkt_e.pkt_cnt);
               checkOutput("sb_err_cnt_at_pkt", m_err, pkt_e.err_cnt);
               checkOutput("sb_len_ovf", m_ovf, pkt_e.len_ovf);
            end
         end
         if (m_orphan || m_restart) begin
            if (err_q.size() == 0) begin
               checkOutput("unexpected_err_pulse", 1, 0);
            end else begin
               err_e = err_q.pop_front();
               checkOutput("sb_err_restart", m_restart, err_e.restart);
               checkOutput("sb_err_orphan", m_orphan, !err_e.restart);
               checkOutput("sb_err_cnt", m_err, err_e.err_cnt);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      idleCycle();
      idleCycle();
      checkOutput("reset_cur_len", m_cur, 0);
      checkOutput("reset_last_len", m_last, 0);
      checkOutput("reset_pkt_cnt", m_pkt, 0);
      checkOutput("reset_err_cnt", m_err, 0);
      checkOutput("reset_in_pkt", m_in_pkt, 0);
      checkOutput("reset_len_ovf", m_ovf, 0);
      checkOutput("reset_last_len_vld", m_vld, 0);
      rst_n = 1'b1;

      $display("[TB] back-to-back packets of 1, 4, 7 words");
      expectPkt(1, 1, 0, 1'b0);
      drivePacket(1, 0);
      expectPkt(4, 2, 0, 1'b0);
      drivePacket(4, 16);
      expectPkt(7, 3, 0, 1'b0);
      drivePacket(7, 32);
      idleCycle();
      checkOutput("b2b_pkt_cnt", m_pkt, 3);
      checkOutput("b2b_err_cnt", m_err, 0);
      checkOutput("b2b_cur_len", m_cur, 7);
      checkOutput("b2b_in_pkt", m_in_pkt, 0);

      $display("[TB] 5-word packet with downstream stalls");
      expectPkt(5, 4, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd10, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd11, 1'b0, 1'b0);
      checkOutput("stall_cur_len", m_cur, 1);
      checkOutput("stall_in_pkt", m_in_pkt, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd11, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd12, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd12, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd13, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd14, 1'b1, 1'b0);
      idleCycle();
      checkOutput("stall_last_len", m_last, 5);

      $display("[TB] orphan beat then restarted packet");
      expectErr(1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd20, 1'b1, 1'b0);
      checkOutput("orphan_cur_len_kept", m_cur, 5);
      expectErr(1'b1, 2);
      expectPkt(3, 5, 2, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd21, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd22, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd23, 1'b1, 1'b0);
      checkOutput("restart_cur_len", m_cur, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd24, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd25, 1'b1, 1'b0);
      idleCycle();
      checkOutput("err_seq_err_cnt", m_err, 2);
      checkOutput("err_seq_pkt_cnt", m_pkt, 5);

      $display("[TB] clear coincident with eop");
      expectPkt(2, 1, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd30, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd31, 1'b1, 1'b1);
      idleCycle();
      checkOutput("clear_eop_pkt_cnt", m_pkt, 1);
      checkOutput("clear_eop_err_cnt", m_err, 0);
      checkOutput("clear_eop_last_len", m_last, 2);
      checkOutput("clear_eop_cur_len", m_cur, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
      checkOutput("clear_only_pkt_cnt", m_pkt, 0);
      checkOutput("clear_only_last_len", m_last, 0);
      checkOutput("clear_only_cur_len", m_cur, 2);

      $display("[TB] reset in the middle of a packet");
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd40, 1'b1, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd41, 1'b1, 1'b0);
      rst_n = 1'b1;
      checkOutput("midrst_cur_len", m_cur, 0);
      checkOutput("midrst_in_pkt", m_in_pkt, 0);
      checkOutput("midrst_pkt_cnt", m_pkt, 0);
      checkOutput("midrst_err_cnt", m_err, 0);
      checkOutput("midrst_last_len", m_last, 0);
      expectPkt(2, 1, 0, 1'b0);
      drivePacket(2, 50);
      idleCycle();
      checkOutput("postrst_last_len", m_last, 2);
      checkOutput("postrst_pkt_cnt", m_pkt, 1);
      checkOutput("postrst_err_cnt", m_err, 0);

      $display("[TB] 10-word packet into 3-bit length counters");
      small_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, i == 0, i == 9, 8'(60 + i), 1'b1, 1'b0);
         if (i == 0) begin
            checkOutput("sink_ready", sat_in.ready, 1);
            checkOutput("sink_out_valid", sat_out.valid, 0);
         end
         if (i == 8) begin
            checkOutput("sat_cur_len_stuck", s_cur, 7);
            checkOutput("wrap_cur_len_mid", w_cur, 1);
         end
      end
      idleCycle();
      checkOutput("sat_last_len", s_last, 7);
      checkOutput("sat_len_ovf", s_ovf, 1);
      checkOutput("sat_cur_len", s_cur, 7);
      checkOutput("sat_pkt_cnt", s_pkt, 1);
      checkOutput("wrap_last_len", w_last, 2);
      checkOutput("wrap_len_ovf", w_ovf, 1);
      checkOutput("wrap_cur_len", w_cur, 2);
      drivePacket(1, 80);
      idleCycle();
      checkOutput("sat_next_last_len", s_last, 1);
      checkOutput("sat_next_len_ovf", s_ovf, 0);
      checkOutput("sat_next_pkt_cnt", s_pkt, 2);
      small_en = 1'b0;

      idleCycle();
      idleCycle();
      checkOutput("pkt_events_outstanding", pkt_q.size(), 0);
      checkOutput("err_events_outstanding", err_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
